apb_slave_mem_responder: RTL and testbench



---
 rtl/apb_slave_mem_responder_if.sv | 22 ++
 rtl/apb_slave_mem_responder.sv | 128 ++++++++++++
 tb/tb_apb_slave_mem_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_mem_responder_if.sv
// APB3 bus bundle between the bridge (master) and the memory responder (slave).
// Sideband pins (wait-state control, checker and counter) stay outside the bundle.
interface apb_slave_mem_responder_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem_responder.sv
// APB3 completer with a word-addressed memory, programmable wait states, PSLVERR
// for illegal addresses, a sticky protocol checker and a completed-transfer counter.
module apb_slave_mem_responder #(
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 256
) (
  input  logic                          PCLK,
  input  logic                          PRESETN,
  apb_slave_mem_responder_if.slave      apb,
  input  logic [3:0]                    WAITCYCLES,
  output logic                          PROTERR,
  output logic [15:0]                   ACCESSCOUNT
);

  localparam int MEMWORDS = 2 ** AWIDTH;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e             state_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               write_q;
  logic               err_q;
  logic [3:0]         cnt_q;
  logic               protErr_q;
  logic [15:0]        accessCount_q;
  logic [15:0]        accessCount_d;
  logic [31:0]        mem_q [MEMWORDS];

  logic [AWIDTH-1:0]  setupIdx;
  logic [23:0]        upperBits;
  logic               setupErr;
  logic [AWIDTH-1:0]  idx_q;
  logic               inAccess;
  logic               ready;
  logic               heldMismatch;

  // Address legality is decided once, from the setup-phase address.
  assign setupIdx  = apb.PADDR[AWIDTH+1:2];
  assign upperBits = apb.PADDR[23:0] >> (AWIDTH + 2);
  assign setupErr  = (apb.PADDR[1:0] != 2'b00) || (upperBits != 24'd0) ||
                     ({{(32-AWIDTH){1'b0}}, setupIdx} >= 32'(DEPTH));

  assign idx_q        = addr_q[AWIDTH+1:2];
  assign inAccess     = (state_q == ACCESS) && apb.PSEL && apb.PENABLE;
  assign ready        = inAccess && (cnt_q == 4'd0);
  assign heldMismatch = (apb.PADDR != addr_q) || (apb.PWRITE != write_q) ||
                        (apb.PWDATA != wdata_q);

  assign apb.PREADY   = ready;
  assign apb.PSLVERR  = ready && err_q;
  assign apb.PRDATA   = (ready && !write_q && !err_q) ? mem_q[idx_q] : 32'd0;
  assign PROTERR      = protErr_q;
  assign ACCESSCOUNT  = accessCount_q;
  assign accessCount_d = accessCount_q + 16'd1;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 4'd0;
      protErr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (apb.PSEL && !apb.PENABLE) begin
            addr_q  <= apb.PADDR;
            wdata_q <= apb.PWDATA;
            write_q <= apb.PWRITE;
            err_q   <= setupErr;
            cnt_q   <= WAITCYCLES;
            state_q <= ACCESS;
          end else if (apb.PSEL && apb.PENABLE) begin
            protErr_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (!apb.PSEL) begin
            protErr_q <= 1'b1;
            state_q   <= IDLE;
          end else if (!apb.PENABLE) begin
            // A re-issued setup abandons the pending transfer and starts afresh.
            protErr_q <= 1'b1;
            addr_q    <= apb.PADDR;
            wdata_q   <= apb.PWDATA;
            write_q   <= apb.PWRITE;
            err_q     <= setupErr;
            cnt_q     <= WAITCYCLES;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
            if (heldMismatch) begin
              protErr_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory commits only in a clean write completion cycle.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      for (int i = 0; i < MEMWORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (ready && write_q && !err_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      accessCount_q <= 16'd0;
    end else if (ready) begin
      accessCount_q <= accessCount_d;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem_responder.sv
// Directed bench for the APB memory responder: a transfer-level memory/counter model
// sets per-cycle expectations, and a negedge process compares every cycle.
module tb_apb_slave_mem_responder;

  localparam int DEPTH = 256;

  logic        PCLK;
  logic        PRESETN;
  logic [3:0]  WAITCYCLES;
  logic        PROTERR;
  logic [15:0] ACCESSCOUNT;

  apb_slave_mem_responder_if bus ();

  apb_slave_mem_responder #(.AWIDTH(8), .DEPTH(DEPTH)) dut (
    .PCLK        (PCLK),
    .PRESETN     (PRESETN),
    .apb         (bus),
    .WAITCYCLES  (WAITCYCLES),
    .PROTERR     (PROTERR),
    .ACCESSCOUNT (ACCESSCOUNT)
  );

  int          vectors = 0;
  int          miscompares = 0;
  bit          checkEn = 1'b0;

  logic [31:0] modelMem [DEPTH];
  int          modelCount;
  logic        expReady;
  logic        expSlverr;
  logic [31:0] expRdata;
  logic        expProtErr;
  logic [15:0] expCount;
  logic [31:0] lastRdata;
  logic        lastSlverr;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle the responder's outputs are held against the model's expectation.
  always @(negedge PCLK) begin
    if (checkEn) begin
      checkOutput("PREADY",      {31'd0, bus.PREADY},  {31'd0, expReady});
      checkOutput("PSLVERR",     {31'd0, bus.PSLVERR}, {31'd0, expSlverr});
      checkOutput("PRDATA",      bus.PRDATA,           expRdata);
      checkOutput("PROTERR",     {31'd0, PROTERR},     {31'd0, expProtErr});
      checkOutput("ACCESSCOUNT", {16'd0, ACCESSCOUNT}, {16'd0, expCount});
    end
  end

  task automatic applyStimulus(input bit sel, input bit en, input bit wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] waits);
    bus.PSEL    = sel;
    bus.PENABLE = en;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = data;
    WAITCYCLES  = waits;
  endtask

  task automatic step();
    @(negedge PCLK);
    lastRdata  = bus.PRDATA;
    lastSlverr = bus.PSLVERR;
    @(posedge PCLK);
    #1;
  endtask

  task automatic clearExp();
    expReady  = 1'b0;
    expSlverr = 1'b0;
    expRdata  = 32'd0;
  endtask

  function automatic bit addrIsBad(input logic [31:0] addr);
    int off;
    off = int'(addr[23:0]);
    return (off % 4 != 0) || (off / 4 >= DEPTH);
  endfunction

  task automatic doTransfer(input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] waits);
    bit err;
    int idx;
    err = addrIsBad(addr);
    idx = int'(addr[23:0]) / 4;
    applyStimulus(1'b1, 1'b0, wr, addr, data, waits);
    clearExp();
    step();
    for (int i = 0; i <= int'(waits); i++) begin
      applyStimulus(1'b1, 1'b1, wr, addr, data, waits);
      if (i == int'(waits)) begin
        expReady  = 1'b1;
        expSlverr = err;
        expRdata  = (!wr && !err) ? modelMem[idx] : 32'd0;
      end
      step();
    end
    if (wr && !err) modelMem[idx] = data;
    modelCount = (modelCount + 1) % 65536;
    expCount   = 16'(modelCount);
    clearExp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      clearExp();
      step();
    end
  endtask

  task automatic doReset();
    PRESETN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 32'd0;
    modelCount = 0;
    expCount   = 16'd0;
    expProtErr = 1'b0;
    clearExp();
    #1;
    checkOutput("rst_PREADY",      {31'd0, bus.PREADY}, 32'd0);
    checkOutput("rst_PRDATA",      bus.PRDATA,          32'd0);
    checkOutput("rst_PROTERR",     {31'd0, PROTERR},    32'd0);
    checkOutput("rst_ACCESSCOUNT", {16'd0, ACCESSCOUNT}, 32'd0);
    step();
    step();
    PRESETN = 1'b1;
    step();
  endtask

  initial begin
    PRESETN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge PCLK);
    #1;
    checkEn = 1'b1;
    doReset();

    // Zero-wait write then read of the same word.
    doTransfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'd0);
    doTransfer(1'b0, 32'h0000_0010, 32'h0, 4'd0);
    checkOutput("zw_rdata",  lastRdata,               32'hDEAD_BEEF);
    checkOutput("zw_slverr", {31'd0, lastSlverr},     32'd0);
    checkOutput("zw_count",  {16'd0, ACCESSCOUNT},    32'd2);
    idle(1);

    // Wait states, including the 16-access-cycle maximum.
    doTransfer(1'b1, 32'h0000_0004, 32'h1234_5678, 4'd2);
    doTransfer(1'b0, 32'h0000_0004, 32'h0, 4'd3);
    checkOutput("ws3_rdata", lastRdata, 32'h1234_5678);
    doTransfer(1'b0, 32'h0000_0004, 32'h0, 4'd15);
    checkOutput("ws15_rdata", lastRdata, 32'h1234_5678);
    idle(1);

    // Misaligned and out-of-range accesses.
    doTransfer(1'b1, 32'h0000_0402, 32'hAAAA_5555, 4'd0);
    checkOutput("err_wr_slverr", {31'd0, lastSlverr}, 32'd1);
    doTransfer(1'b0, 32'h0000_0400, 32'h0, 4'd1);
    checkOutput("err_rd_slverr", {31'd0, lastSlverr}, 32'd1);
    checkOutput("err_rd_rdata",  lastRdata,           32'd0);
    doTransfer(1'b0, 32'h0000_0000, 32'h0, 4'd0);
    checkOutput("err_word0", lastRdata, 32'd0);
    idle(1);

    // Back-to-back writes, then read them back.
    for (int i = 0; i < 4; i++) begin
      doTransfer(1'b1, 32'h40 + 32'(4 * i), 32'h0000_1000 + 32'(i), 4'd0);
    end
    for (int i = 0; i < 4; i++) begin
      doTransfer(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'd0);
    end
    checkOutput("b2b_last_rdata", lastRdata, 32'h0000_1003);
    checkOutput("b2b_count", {16'd0, ACCESSCOUNT}, 32'd16);
    idle(1);

    // Access phase straight from IDLE.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'd0);
    clearExp();
    step();
    expProtErr = 1'b1;
    idle(1);
    checkOutput("noset_proterr", {31'd0, PROTERR}, 32'd1);
    doReset();

    // Address change during a wait state, then the bridge gives up.
    doTransfer(1'b1, 32'h30, 32'h3333_3333, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, 4'd4);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 4'd4);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h34, 32'hCAFE_F00D, 4'd4);
    step();
    expProtErr = 1'b1;
    idle(1);
    doTransfer(1'b0, 32'h30, 32'h0, 4'd0);
    checkOutput("addrchg_mem", lastRdata, 32'h3333_3333);
    checkOutput("addrchg_count", {16'd0, ACCESSCOUNT}, 32'd2);
    doReset();

    // PSEL drops mid-wait.
    doTransfer(1'b1, 32'h34, 32'h1111_1111, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h34, 32'h2222_2222, 4'd4);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h34, 32'h2222_2222, 4'd4);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h34, 32'h2222_2222, 4'd4);
    step();
    idle(1);
    expProtErr = 1'b1;
    idle(1);
    doTransfer(1'b0, 32'h34, 32'h0, 4'd0);
    checkOutput("psel_drop_mem", lastRdata, 32'h1111_1111);
    checkOutput("psel_drop_count", {16'd0, ACCESSCOUNT}, 32'd2);

    // Reset lands in the middle of a write's wait states.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 32'h55AA_55AA, 4'd5);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h20, 32'h55AA_55AA, 4'd5);
    step();
    step();
    doReset();
    doTransfer(1'b0, 32'h20, 32'h0, 4'd0);
    checkOutput("rst_mid_mem", lastRdata, 32'd0);
    idle(1);

    // Counter wrap from a preloaded 0xFFFF.
    force dut.accessCount_q = 16'hFFFF;
    #2;
    release dut.accessCount_q;
    modelCount = 65535;
    expCount   = 16'hFFFF;
    idle(1);
    doTransfer(1'b1, 32'h8, 32'h0BAD_F00D, 4'd0);
    checkOutput("wrap_count", {16'd0, ACCESSCOUNT}, 32'd0);
    idle(2);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
